// File: rtl/eth_tx_arbiter.sv
// Two-port packet arbiter for the shared UDP/RGMII transmit engine.
// Command sender (port 0) and picture sender (port 1). Adds an inter-packet gap, bounds command bursts and recovers from a hung TX core.
module eth_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int CMD_BURST_MAX = 4,
  parameter int WDOG_CYCLES   = 1_000_000,
  parameter int WDOG_W        = 20
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic cmd_req,
  output logic cmd_gnt,
  output logic cmd_done,
  input  logic pic_req,
  output logic pic_gnt,
  output logic pic_done,
  output logic tx_start,
  output logic tx_sel,
  input  logic tx_done,
  output logic tx_abort,
  output logic busy,
  output logic err_timeout
);

  localparam int GAP_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int BURST_W = $clog2(CMD_BURST_MAX + 1);
  localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(IFG_CYCLES - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CMD_BURST_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t               state_q;
  logic [WDOG_W-1:0]    wdog_q;
  logic [GAP_W-1:0]     gap_q;
  logic [BURST_W-1:0]   burst_q;
  logic                 cmd_gnt_q, pic_gnt_q, cmd_done_q, pic_done_q;
  logic                 tx_start_q, tx_sel_q, tx_abort_q, busy_q, err_q;
  logic                 pic_win_d;
  logic                 owner_req_d;

  // Pick the next owner; pic is forced once cmd has used up its burst allowance.
  always_comb begin
    pic_win_d = 1'b0;
    if (cmd_req && (!pic_req || (burst_q < BURST_MAX))) begin
      pic_win_d = 1'b0;
    end else if (pic_req) begin
      pic_win_d = 1'b1;
    end else begin
      pic_win_d = 1'b0;
    end
  end

  // Request of the currently selected owner, rechecked just before granting.
  always_comb begin
    owner_req_d = 1'b0;
    if (tx_sel_q) begin
      owner_req_d = pic_req;
    end else begin
      owner_req_d = cmd_req;
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wdog_q     <= '0;
      gap_q      <= '0;
      burst_q    <= '0;
      cmd_gnt_q  <= 1'b0;
      pic_gnt_q  <= 1'b0;
      cmd_done_q <= 1'b0;
      pic_done_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_sel_q   <= 1'b0;
      tx_abort_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cmd_gnt_q  <= 1'b0;
      pic_gnt_q  <= 1'b0;
      cmd_done_q <= 1'b0;
      pic_done_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_req || pic_req) begin
            tx_sel_q <= pic_win_d;
            state_q  <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A request withdrawn before its grant gets nothing.
          if (owner_req_d) begin
            cmd_gnt_q  <= ~tx_sel_q;
            pic_gnt_q  <= tx_sel_q;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            wdog_q     <= '0;
            if (!tx_sel_q && pic_req) begin
              burst_q <= (burst_q < BURST_MAX) ? burst_q + BURST_W'(1) : BURST_MAX;
            end else begin
              burst_q <= '0;
            end
            state_q <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            cmd_done_q <= ~tx_sel_q;
            pic_done_q <= tx_sel_q;
            gap_q      <= '0;
            state_q    <= S_GAP;
          end else if (wdog_q == WDOG_LAST) begin
            cmd_done_q <= ~tx_sel_q;
            pic_done_q <= tx_sel_q;
            tx_abort_q <= 1'b1;
            err_q      <= 1'b1;
            gap_q      <= '0;
            state_q    <= S_GAP;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_gnt     = cmd_gnt_q;
  assign pic_gnt     = pic_gnt_q;
  assign cmd_done    = cmd_done_q;
  assign pic_done    = pic_done_q;
  assign tx_start    = tx_start_q;
  assign tx_sel      = tx_sel_q;
  assign tx_abort    = tx_abort_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule
